// File: rtl/mag_sq_pipe_pkg.sv
// Shared constants and width helpers for the squared-magnitude pipeline.
// Build option: MAG_SQ_SAT_EN selects the shifted, saturated WIDTH-bit output.
// Without it, outputs are full-precision 2*WIDTH-bit values.
package mag_sq_pkg;

  localparam int DEF_WIDTH    = 16;
  localparam int DEF_CHANNELS = 4;
  // Clocks from an accepted input beat to out_valid; identical in both builds.
  localparam int LAT          = 4;

  // Output magnitude width: saturated to WIDTH bits, or full 2*WIDTH precision.
  function automatic int outWidth(input int width);
`ifdef MAG_SQ_SAT_EN
    return width;
`else
    return 2 * width;
`endif
  endfunction

  // Argmin index width; never zero so the port stays legal.
  function automatic int idxWidth(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/mag_sq_pipe_lane.sv
// One channel of the squared-magnitude datapath (stages S1..S3).
// The advance input is a clock enable; when it is low, every stage holds.
// Build option: MAG_SQ_SAT_EN shifts the S3 sum right by SHIFT and then
// saturates it to WIDTH unsigned bits.
module mag_sq_lane
  import mag_sq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SHIFT = 0,
  parameter int OW    = outWidth(WIDTH)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    advance,
  input  logic signed [WIDTH-1:0] re,
  input  logic signed [WIDTH-1:0] im,
  output logic        [OW-1:0]    mag
);

  localparam int PW = 2 * WIDTH;

  logic signed [WIDTH-1:0] reP1, imP1;
  logic signed [PW-1:0]    reExtP1, imExtP1;
  logic signed [PW-1:0]    reSqP2, imSqP2;
  logic        [PW-1:0]    sumP2;
  logic        [OW-1:0]    magNextP2;
  logic        [OW-1:0]    magP3;

  // Shift right by SHIFT; any surviving bit above WIDTH-1 forces all-ones.
  function automatic logic [WIDTH-1:0] satShift(input logic [PW-1:0] x);
    logic [PW-1:0] s;
    s = x >> SHIFT;
    if (|s[PW-1:WIDTH]) return '1;
    return s[WIDTH-1:0];
  endfunction

  // Sign-extend before squaring so the product keeps its full 2*WIDTH precision.
  assign reExtP1 = PW'(reP1);
  assign imExtP1 = PW'(imP1);

  // Both squares are non-negative and at most 2^(2W-2), so the sum fits unsigned.
  assign sumP2 = $unsigned(reSqP2) + $unsigned(imSqP2);

`ifdef MAG_SQ_SAT_EN
  assign magNextP2 = satShift(sumP2);
`else
  assign magNextP2 = sumP2;
`endif

  // S1: register the raw complex sample.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reP1 <= '0;
      imP1 <= '0;
    end else if (advance) begin
      reP1 <= re;
      imP1 <= im;
    end
  end

  // S2: register the signed squares.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reSqP2 <= '0;
      imSqP2 <= '0;
    end else if (advance) begin
      reSqP2 <= reExtP1 * reExtP1;
      imSqP2 <= imExtP1 * imExtP1;
    end
  end

  // S3: register the unsigned sum, saturated when that option is built in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      magP3 <= '0;
    end else if (advance) begin
      magP3 <= magNextP2;
    end
  end

  assign mag = magP3;

endmodule

// File: rtl/mag_sq_pipe.sv
// Multi-channel squared-magnitude pipeline with a registered argmin stage.
// Four stages, all stalled together by a single global advance signal.
// Build option: MAG_SQ_SAT_EN gives WIDTH-bit saturated magnitudes; the
// default build gives full-precision 2*WIDTH-bit magnitudes.
module mag_sq_pipe
  import mag_sq_pkg::*;
#(
  parameter int  WIDTH    = DEF_WIDTH,
  parameter int  CHANNELS = DEF_CHANNELS,
  parameter int  IDX_W    = idxWidth(CHANNELS),
  parameter int  SHIFT    = 0,
  localparam int OW       = outWidth(WIDTH)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [CHANNELS*WIDTH-1:0] in_real,
  input  logic [CHANNELS*WIDTH-1:0] in_imag,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*OW-1:0]    out_mag,
  output logic [IDX_W-1:0]          out_min_idx,
  output logic [OW-1:0]             out_min_val
);

  logic                   advance;
  logic                   vldP1, vldP2, vldP3;
  logic [CHANNELS*OW-1:0] magP3;
  logic [IDX_W-1:0]       minIdxP3;
  logic [OW-1:0]          minValP3;

  // The whole pipe moves only when the output slot is empty or being consumed.
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  for (genvar k = 0; k < CHANNELS; k++) begin : gLane
    mag_sq_lane #(
      .WIDTH (WIDTH),
      .SHIFT (SHIFT),
      .OW    (OW)
    ) uLane (
      .clk     (clk),
      .rst     (rst),
      .advance (advance),
      .re      (in_real[k*WIDTH +: WIDTH]),
      .im      (in_imag[k*WIDTH +: WIDTH]),
      .mag     (magP3[k*OW +: OW])
    );
  end

  // Argmin over the S3 magnitudes; strict less-than makes ties go to the lowest index.
  always_comb begin
    minIdxP3 = '0;
    minValP3 = magP3[0 +: OW];
    for (int k = 1; k < CHANNELS; k++) begin
      if (magP3[k*OW +: OW] < minValP3) begin
        minValP3 = magP3[k*OW +: OW];
        minIdxP3 = IDX_W'(k);
      end
    end
  end

  // S1..S3 valid chain; idle slots travel through as bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vldP1 <= 1'b0;
      vldP2 <= 1'b0;
      vldP3 <= 1'b0;
    end else if (advance) begin
      vldP1 <= in_valid;
      vldP2 <= vldP1;
      vldP3 <= vldP2;
    end
  end

  // S4: output register holding the magnitudes and the argmin result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid   <= 1'b0;
      out_mag     <= '0;
      out_min_idx <= '0;
      out_min_val <= '0;
    end else if (advance) begin
      out_valid   <= vldP3;
      out_mag     <= magP3;
      out_min_idx <= minIdxP3;
      out_min_val <= minValP3;
    end
  end

endmodule

// File: tb/tb_mag_sq_pipe.sv
// Scoreboard bench for mag_sq_pipe (CHANNELS=4, WIDTH=16).
// With MAG_SQ_SAT_EN defined, it runs with SHIFT=4 and adds saturation vectors.
module tb_mag_sq_pipe;
  import mag_sq_pkg::*;

  localparam int W  = 16;
  localparam int CH = 4;
  localparam int OW = outWidth(W);
  localparam int IW = idxWidth(CH);
`ifdef MAG_SQ_SAT_EN
  localparam int SH = 4;
`else
  localparam int SH = 0;
`endif

  logic              clk, rst;
  logic              in_valid, in_ready, out_valid, out_ready;
  logic [CH*W-1:0]   in_real, in_imag;
  logic [CH*OW-1:0]  out_mag;
  logic [IW-1:0]     out_min_idx;
  logic [OW-1:0]     out_min_val;

  typedef struct {
    logic [CH*OW-1:0] mag;
    logic [IW-1:0]    idx;
    logic [OW-1:0]    val;
  } exp_t;

  exp_t sbQ[$];
  int   nChecks = 0;
  int   nFails  = 0;

  mag_sq_pipe #(.WIDTH(W), .CHANNELS(CH), .IDX_W(IW), .SHIFT(SH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_real     (in_real),
    .in_imag     (in_imag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_mag     (out_mag),
    .out_min_idx (out_min_idx),
    .out_min_val (out_min_val)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkVal(input string tag, input logic [127:0] got, input logic [127:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [CH*W-1:0] pack(input int a, input int b, input int c, input int d);
    logic [CH*W-1:0] p;
    p[0*W +: W] = W'(a);
    p[1*W +: W] = W'(b);
    p[2*W +: W] = W'(c);
    p[3*W +: W] = W'(d);
    return p;
  endfunction

  function automatic logic [CH*OW-1:0] packOut(input longint a, input longint b, input longint c, input longint d);
    logic [CH*OW-1:0] p;
    p[0*OW +: OW] = OW'(a);
    p[1*OW +: OW] = OW'(b);
    p[2*OW +: OW] = OW'(c);
    p[3*OW +: OW] = OW'(d);
    return p;
  endfunction

  // Reference model: 64-bit integer arithmetic, optional shift and clamp, argmin scan.
  function automatic exp_t model(input logic [CH*W-1:0] re, input logic [CH*W-1:0] im);
    exp_t          e;
    longint        r, i, m;
    logic [OW-1:0] mv;
    e.mag = '0;
    e.idx = '0;
    e.val = '0;
    for (int k = 0; k < CH; k++) begin
      r = longint'($signed(re[k*W +: W]));
      i = longint'($signed(im[k*W +: W]));
      m = r * r + i * i;
`ifdef MAG_SQ_SAT_EN
      m = m >>> SH;
      if (m > ((longint'(1) << W) - 1)) m = (longint'(1) << W) - 1;
`endif
      mv = OW'(m);
      e.mag[k*OW +: OW] = mv;
      if (k == 0 || mv < e.val) begin
        e.val = mv;
        e.idx = IW'(k);
      end
    end
    return e;
  endfunction

  // Monitor: push on accepted input, pop and compare on consumed output.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst) begin
      if (in_valid && in_ready) sbQ.push_back(model(in_real, in_imag));
      if (out_valid && out_ready) begin
        if (sbQ.size() == 0) begin
          checkVal("sb_underflow", 128'(out_valid), 128'(0));
        end else begin
          e = sbQ.pop_front();
          checkVal("out_mag", 128'(out_mag), 128'(e.mag));
          checkVal("out_min_idx", 128'(out_min_idx), 128'(e.idx));
          checkVal("out_min_val", 128'(out_min_val), 128'(e.val));
        end
      end
    end
  end

  // Present one beat and hold it until accepted; returns just after the accepting edge.
  task automatic sendBeat(input logic [CH*W-1:0] re, input logic [CH*W-1:0] im);
    int n;
    n = 0;
    in_real  = re;
    in_imag  = im;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) checkVal("accept_timeout", 128'(in_ready), 128'(1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Send one beat into an empty pipe and check out_valid rises exactly LAT clocks later.
  task automatic runLatency(input string tag, input logic [CH*W-1:0] re, input logic [CH*W-1:0] im);
    sendBeat(re, im);
    for (int c = 1; c <= LAT; c++) begin
      @(negedge clk);
      if (c == LAT - 1) checkVal({tag, "_early"}, 128'(out_valid), 128'(0));
      if (c == LAT)     checkVal({tag, "_valid"}, 128'(out_valid), 128'(1));
    end
  endtask

  task automatic waitDrain(input string tag);
    int n;
    n = 0;
    while (sbQ.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkVal(tag, 128'(sbQ.size()), 128'(0));
    @(posedge clk);
    #1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    logic [CH*OW-1:0] heldMag;
    logic [IW-1:0]    heldIdx;
    logic [OW-1:0]    heldVal;

    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    in_real   = '0;
    in_imag   = '0;
    repeat (2) @(posedge clk);
    #1;
    checkVal("rst_out_valid", 128'(out_valid), 128'(0));
    checkVal("rst_out_mag", 128'(out_mag), 128'(0));
    checkVal("rst_min_idx", 128'(out_min_idx), 128'(0));
    checkVal("rst_min_val", 128'(out_min_val), 128'(0));
    checkVal("rst_in_ready", 128'(in_ready), 128'(1));
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single beat with known answer: {25,2,4,25}, argmin 1.
    runLatency("lat1", pack(3, 1, 0, -5), pack(4, 1, -2, 0));
`ifndef MAG_SQ_SAT_EN
    checkVal("t1_mag", 128'(out_mag), 128'(packOut(25, 2, 4, 25)));
    checkVal("t1_idx", 128'(out_min_idx), 128'(1));
    checkVal("t1_val", 128'(out_min_val), 128'(2));
`endif
    waitDrain("drain_t1");

    // Back-to-back directed vectors: extremes, ties, last-index minimum.
    sendBeat(pack(-32768, -32768, -32768, -32768), pack(-32768, -32768, -32768, -32768));
    sendBeat(pack(32767, 1, 2, 0), pack(0, 1, 0, 3));
    sendBeat(pack(3, 0, -3, 0), pack(0, 3, 0, -3));
    sendBeat(pack(3, 1, 1, 2), pack(1, 1, -1, 2));
    sendBeat(pack(0, 0, 0, 0), pack(0, 0, 0, 0));
    sendBeat(pack(5, 4, 3, -1), pack(5, 4, 3, 0));
`ifdef MAG_SQ_SAT_EN
    sendBeat(pack(1000, 100, 0, 1000), pack(0, 0, 100, 1000));
`endif
    waitDrain("drain_directed");
`ifndef MAG_SQ_SAT_EN
    runLatency("lat_ext", pack(-32768, 32767, -32768, 32767), pack(-32768, 0, -32768, 0));
    checkVal("ext_mag", 128'(out_mag), 128'(packOut(64'h80000000, 64'h3FFF0001, 64'h80000000, 64'h3FFF0001)));
    checkVal("ext_idx", 128'(out_min_idx), 128'(1));
    waitDrain("drain_ext");
`endif

    // Random stream of 10 beats with a 5-clock output stall in the middle.
    fork
      begin
        for (int b = 0; b < 10; b++) sendBeat({$urandom, $urandom}, {$urandom, $urandom});
      end
      begin
        repeat (6) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        heldMag = out_mag;
        heldIdx = out_min_idx;
        heldVal = out_min_val;
        for (int s = 0; s < 5; s++) begin
          if (s > 0) @(negedge clk);
          checkVal("stall_in_ready", 128'(in_ready), 128'(0));
          checkVal("stall_out_valid", 128'(out_valid), 128'(1));
          if (s > 0) begin
            checkVal("stall_mag_hold", 128'(out_mag), 128'(heldMag));
            checkVal("stall_idx_hold", 128'(out_min_idx), 128'(heldIdx));
            checkVal("stall_val_hold", 128'(out_min_val), 128'(heldVal));
          end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    waitDrain("drain_stall");

    // Reset with beats in flight: outputs clear immediately, then a fresh beat.
    for (int b = 0; b < 5; b++) sendBeat(pack(b, 2, 3, 4), pack(1, b, 1, 1));
    checkVal("pre_rst_valid", 128'(out_valid), 128'(1));
    rst = 1'b1;
    #1;
    checkVal("mid_rst_valid", 128'(out_valid), 128'(0));
    checkVal("mid_rst_mag", 128'(out_mag), 128'(0));
    checkVal("mid_rst_idx", 128'(out_min_idx), 128'(0));
    checkVal("mid_rst_val", 128'(out_min_val), 128'(0));
    checkVal("mid_rst_ready", 128'(in_ready), 128'(1));
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    checkVal("post_rst_valid", 128'(out_valid), 128'(0));
    @(posedge clk);
    #1;
    runLatency("lat_post_rst", pack(7, 2, 2, 9), pack(0, 1, -1, 0));
    waitDrain("drain_post_rst");

    $display("%0d/%0d checks passed", nChecks - nFails, nChecks);
    $finish;
  end

endmodule
